// File: rtl/sram_axi_tester.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_tester
// Description : Looping external async-SRAM tester. A pattern sequencer
//               writes then reads back every address over an internal
//               AXI-lite-style link to a 3-cycle SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_tester #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 test_done,
    output logic                 test_pass,
    output logic [2:0]           pattern_state,
    output logic [DATA_BITS-1:0] expected_data,
    output logic [DATA_BITS-1:0] read_data,
    output logic [ADDR_BITS-1:0] iter_addr,
    output logic [ADDR_BITS-1:0] sram_io_addr,
    inout  wire  [DATA_BITS-1:0] sram_io_data,
    output logic                 sram_io_we_n,
    output logic                 sram_io_oe_n,
    output logic                 sram_io_ce_n
);
    localparam logic [ADDR_BITS-1:0] c_last_addr    = '1;
    localparam logic [2:0]           c_last_pattern = 3'd5;

    typedef enum logic [2:0] {
        S_WRITE      = 3'd0,
        S_WRITE_WAIT = 3'd1,
        S_READ       = 3'd2,
        S_READ_WAIT  = 3'd3,
        S_CHECK      = 3'd4
    } seq_state_t;

    typedef enum logic [2:0] {
        C_IDLE  = 3'd0,
        C_W1    = 3'd1,
        C_W2    = 3'd2,
        C_W3    = 3'd3,
        C_BRESP = 3'd4,
        C_R1    = 3'd5,
        C_R2    = 3'd6,
        C_R3    = 3'd7
    } ctl_state_t;

    // Internal AXI-lite link; responses are always OKAY so no resp fields.
    logic                 w_awvalid, w_awready, w_wvalid, w_wready;
    logic                 r_bvalid, w_bready;
    logic                 w_arvalid, w_arready;
    logic                 r_rvalid, w_rready;
    logic [ADDR_BITS-1:0] w_awaddr, w_araddr;
    logic [DATA_BITS-1:0] w_wdata, r_rdata;

    // ------------------------------------------------------------------
    // Pattern sequencer
    // ------------------------------------------------------------------
    seq_state_t           r_seq, w_seq_next;
    logic [ADDR_BITS-1:0] r_iter_addr;
    logic [2:0]           r_pattern;
    logic                 r_pass, r_done;
    logic [DATA_BITS-1:0] r_read_data, w_expected, w_alt;
    logic                 w_last_addr;

    assign w_last_addr = (r_iter_addr == c_last_addr);

    always_comb begin
        w_alt      = '0;
        w_expected = '0;
        for (int i = 0; i < DATA_BITS; i += 2) begin
            w_alt[i] = 1'b1;
        end
        case (r_pattern)
            3'd0:    w_expected = '0;
            3'd1:    w_expected = '1;
            3'd2:    w_expected = w_alt;
            3'd3:    w_expected = ~w_alt;
            3'd4:    w_expected = DATA_BITS'(r_iter_addr);
            3'd5:    w_expected = ~(DATA_BITS'(r_iter_addr));
            default: w_expected = '0;
        endcase
    end

    always_comb begin
        w_seq_next = r_seq;
        w_awvalid  = 1'b0;
        w_wvalid   = 1'b0;
        w_bready   = 1'b0;
        w_arvalid  = 1'b0;
        w_rready   = 1'b0;
        case (r_seq)
            S_WRITE: begin
                w_awvalid = 1'b1;
                w_wvalid  = 1'b1;
                if (w_awready && w_wready) w_seq_next = S_WRITE_WAIT;
            end
            S_WRITE_WAIT: begin
                w_bready = 1'b1;
                if (r_bvalid) w_seq_next = w_last_addr ? S_READ : S_WRITE;
            end
            S_READ: begin
                w_arvalid = 1'b1;
                if (w_arready) w_seq_next = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                w_rready = 1'b1;
                if (r_rvalid) w_seq_next = S_CHECK;
            end
            S_CHECK:  w_seq_next = w_last_addr ? S_WRITE : S_READ;
            default:  w_seq_next = S_WRITE;
        endcase
    end

    assign w_awaddr = r_iter_addr;
    assign w_araddr = r_iter_addr;
    assign w_wdata  = w_expected;

    always_ff @(posedge clk) begin
        if (reset) r_seq <= S_WRITE;
        else       r_seq <= w_seq_next;
    end

    // Address increment wraps to 0 naturally after the last address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iter_addr <= '0;
            r_pattern   <= 3'd0;
            r_pass      <= 1'b1;
            r_done      <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_seq == S_WRITE_WAIT && r_bvalid) begin
                r_iter_addr <= r_iter_addr + 1'b1;
            end
            if (r_seq == S_READ_WAIT && r_rvalid) begin
                r_read_data <= r_rdata;
            end
            if (r_seq == S_CHECK) begin
                if (r_read_data != w_expected) r_pass <= 1'b0;
                r_iter_addr <= r_iter_addr + 1'b1;
                if (w_last_addr) begin
                    if (r_pattern == c_last_pattern) begin
                        r_pattern <= 3'd0;
                        r_done    <= 1'b1;
                    end else begin
                        r_pattern <= r_pattern + 3'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Async SRAM controller
    // ------------------------------------------------------------------
    ctl_state_t           r_ctl, w_ctl_next;
    logic                 r_ce_n, r_oe_n, r_we_n, r_drive;
    logic [ADDR_BITS-1:0] r_sram_addr;
    logic [DATA_BITS-1:0] r_sram_wdata;

    // Writes take priority; the sequencer never requests both at once.
    assign w_awready = (r_ctl == C_IDLE) && w_awvalid && w_wvalid;
    assign w_wready  = w_awready;
    assign w_arready = (r_ctl == C_IDLE) && !(w_awvalid && w_wvalid);

    always_comb begin
        w_ctl_next = r_ctl;
        case (r_ctl)
            C_IDLE: begin
                if (w_awvalid && w_wvalid) w_ctl_next = C_W1;
                else if (w_arvalid)        w_ctl_next = C_R1;
            end
            C_W1:    w_ctl_next = C_W2;
            C_W2:    w_ctl_next = C_W3;
            C_W3:    w_ctl_next = C_BRESP;
            C_BRESP: if (w_bready) w_ctl_next = C_IDLE;
            C_R1:    w_ctl_next = C_R2;
            C_R2:    w_ctl_next = C_R3;
            C_R3:    if (w_rready) w_ctl_next = C_IDLE;
            default: w_ctl_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_ctl <= C_IDLE;
        else       r_ctl <= w_ctl_next;
    end

    // Pins are registered decodes of the next state, so each phase is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_drive      <= 1'b0;
            r_bvalid     <= 1'b0;
            r_rvalid     <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_rdata      <= '0;
        end else begin
            r_ce_n   <= !(w_ctl_next inside {C_W1, C_W2, C_W3, C_R1, C_R2});
            r_oe_n   <= !(w_ctl_next inside {C_R1, C_R2});
            r_we_n   <= (w_ctl_next != C_W2);
            r_drive  <= (w_ctl_next inside {C_W1, C_W2, C_W3});
            r_bvalid <= (w_ctl_next == C_BRESP);
            r_rvalid <= (w_ctl_next == C_R3);
            if (w_awvalid && w_awready) begin
                r_sram_addr  <= w_awaddr;
                r_sram_wdata <= w_wdata;
            end else if (w_arvalid && w_arready) begin
                r_sram_addr <= w_araddr;
            end
            if (r_ctl == C_R2) r_rdata <= sram_io_data;
        end
    end

    assign sram_io_data  = r_drive ? r_sram_wdata : 'z;
    assign sram_io_addr  = r_sram_addr;
    assign sram_io_we_n  = r_we_n;
    assign sram_io_oe_n  = r_oe_n;
    assign sram_io_ce_n  = r_ce_n;

    assign test_done     = r_done;
    assign test_pass     = r_pass;
    assign pattern_state = r_pattern;
    assign expected_data = w_expected;
    assign read_data     = r_read_data;
    assign iter_addr     = r_iter_addr;

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_axi_tester
// Description : Bench for sram_axi_tester with a behavioural async SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_axi_tester;
    localparam int AB = 4;
    localparam int DB = 2;
    localparam int NADDR = 1 << AB;
    localparam int BUDGET = 6 * 2 * NADDR * 6;
    localparam int LIMIT = 10000;

    logic          clk;
    logic          reset;
    logic          test_done, test_pass;
    logic [2:0]    pattern_state;
    logic [DB-1:0] expected_data, read_data;
    logic [AB-1:0] iter_addr, sram_addr;
    wire  [DB-1:0] sram_data;
    logic          we_n, oe_n, ce_n;

    sram_axi_tester #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .reset         (reset),
        .test_done     (test_done),
        .test_pass     (test_pass),
        .pattern_state (pattern_state),
        .expected_data (expected_data),
        .read_data     (read_data),
        .iter_addr     (iter_addr),
        .sram_io_addr  (sram_addr),
        .sram_io_data  (sram_data),
        .sram_io_we_n  (we_n),
        .sram_io_oe_n  (oe_n),
        .sram_io_ce_n  (ce_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural async SRAM with optional stuck-at-0 on data bit 0.
    logic [DB-1:0] mem [0:NADDR-1];
    logic          fault;
    logic [DB-1:0] sa0_mask;
    assign sa0_mask  = fault ? 2'b10 : 2'b11;
    assign sram_data = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 'z;
    always @(negedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr] <= sram_data & sa0_mask;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [DB-1:0] pat_val(input int p, input int a);
        case (p)
            0:       return 2'b00;
            1:       return 2'b11;
            2:       return 2'b01;
            3:       return 2'b10;
            4:       return a[DB-1:0];
            5:       return ~a[DB-1:0];
            default: return 2'b00;
        endcase
    endfunction

    // Reference model: tracks each SRAM read seen on the pins and predicts
    // the sequencer outputs that follow it.
    logic          model_pass = 1'b1;
    logic          exp_done;
    int            pend = -1;
    logic          rd_seen = 1'b0, we_seen = 1'b0;
    logic [AB-1:0] rd_addr, w_addr, nxt_addr;
    logic [DB-1:0] rd_val, w_data;
    int            rd_pat;
    int            fail_addr = -1, fail_pat = -1;

    always @(negedge clk) begin
        if (reset) begin
            model_pass = 1'b1;
            pend       = -1;
            rd_seen    = 1'b0;
            we_seen    = 1'b0;
            fail_addr  = -1;
            fail_pat   = -1;
        end else begin
            check("expected_data", expected_data, pat_val(int'(pattern_state), int'(iter_addr)));
            check("pattern_range", pattern_state <= 3'd5, 1'b1);
            check("oe_we_overlap", (oe_n || we_n), 1'b1);
            if (!oe_n) check("bus_during_read", sram_data, mem[sram_addr]);

            if (!we_n && !we_seen) begin
                w_addr = sram_addr;
                w_data = sram_data;
            end
            if (!we_n || we_seen) begin
                check("we_addr_stable", sram_addr, w_addr);
                check("we_data_stable", sram_data, w_data);
                check("we_ce_low", ce_n, 1'b0);
            end
            we_seen = !we_n;

            exp_done = 1'b0;
            if (pend > 0) pend--;
            if (pend == 0) begin
                nxt_addr = rd_addr + 1'b1;
                check("read_data", read_data, rd_val);
                check("iter_after_read", iter_addr, nxt_addr);
                check("pattern_after_read", pattern_state,
                      (rd_addr == AB'(NADDR - 1)) ? ((rd_pat == 5) ? 0 : rd_pat + 1) : rd_pat);
                if (rd_val != pat_val(rd_pat, int'(rd_addr))) begin
                    if (model_pass) begin
                        fail_addr = int'(rd_addr);
                        fail_pat  = rd_pat;
                    end
                    model_pass = 1'b0;
                end
                exp_done = (rd_pat == 5) && (rd_addr == AB'(NADDR - 1));
                pend = -1;
            end
            if (!oe_n) begin
                rd_addr = sram_addr;
                rd_val  = sram_data;
                rd_pat  = int'(pattern_state);
                rd_seen = 1'b1;
            end else if (rd_seen) begin
                rd_seen = 1'b0;
                pend    = 2;
            end
            check("test_pass", test_pass, model_pass);
            check("test_done", test_done, exp_done);
        end
    end

    int   nd, k1, k2, kb, fall_pat;
    logic prev_d, found, fell;
    logic s1, s2, s3, s4, s5;

    initial begin
        reset = 1'b1;
        fault = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_pass", test_pass, 1'b1);
        check("rst_done", test_done, 1'b0);
        check("rst_pattern", pattern_state, 3'd0);
        check("rst_iter", iter_addr, 4'd0);
        check("rst_read_data", read_data, 2'd0);
        check("rst_we_n", we_n, 1'b1);
        check("rst_oe_n", oe_n, 1'b1);
        check("rst_ce_n", ce_n, 1'b1);
        check("rst_expected", expected_data, 2'b00);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Two full passes from reset; sample index 0 is the first post-reset cycle.
        nd = 0; k1 = 0; k2 = 0; prev_d = 1'b0;
        {s1, s2, s3, s4, s5} = '0;
        for (int k = 0; k < LIMIT; k++) begin
            if (prev_d) check("done_width", test_done, 1'b0);
            if (test_done) begin
                nd++;
                if (nd == 1) k1 = k;
                if (nd == 2) k2 = k;
            end
            if (pattern_state == 3'd1 && !s1) begin s1 = 1'b1; check("p1_value", expected_data, 2'b11); end
            if (pattern_state == 3'd2 && !s2) begin s2 = 1'b1; check("p2_value", expected_data, 2'b01); end
            if (pattern_state == 3'd3 && !s3) begin s3 = 1'b1; check("p3_value", expected_data, 2'b10); end
            if (pattern_state == 3'd4 && iter_addr == 4'd13 && !s4) begin
                s4 = 1'b1; check("p4_a13", expected_data, 2'b01);
            end
            if (pattern_state == 3'd5 && iter_addr == 4'd13 && !s5) begin
                s5 = 1'b1; check("p5_a13", expected_data, 2'b10);
            end
            if (nd == 2) break;
            prev_d = test_done;
            @(negedge clk);
        end
        check("done_count", nd, 2);
        check("done_interval_equal", k2 - k1, k1);
        check("done_within_budget", k1 <= BUDGET, 1'b1);
        check("pass_after_two", test_pass, 1'b1);

        // Reset in the middle of the pattern-3 read phase.
        found = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            if (pattern_state == 3'd3 && !oe_n) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("reach_p3_read", found, 1'b1);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ce_n", ce_n, 1'b1);
        check("mid_rst_oe_n", oe_n, 1'b1);
        check("mid_rst_we_n", we_n, 1'b1);
        check("mid_rst_pattern", pattern_state, 3'd0);
        check("mid_rst_iter", iter_addr, 4'd0);
        check("mid_rst_pass", test_pass, 1'b1);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        kb = -1;
        for (int k = 0; k < LIMIT; k++) begin
            if (test_done) begin kb = k; break; end
            @(negedge clk);
        end
        check("pass_after_mid_reset", kb, k1);
        check("pass_flag_after_mid_reset", test_pass, 1'b1);

        // Stuck-at-0 on data bit 0.
        @(posedge clk);
        #2 begin fault = 1'b1; reset = 1'b1; end
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        nd = 0; fell = 1'b0; fall_pat = -1;
        for (int k = 0; k < LIMIT; k++) begin
            if (!test_pass && !fell) begin fell = 1'b1; fall_pat = int'(pattern_state); end
            if (test_done) nd++;
            if (nd == 2) break;
            @(negedge clk);
        end
        check("fault_fell", fell, 1'b1);
        check("fault_fall_pattern", fall_pat, 1);
        check("fault_first_addr", fail_addr, 0);
        check("fault_first_pattern", fail_pat, 1);
        check("fault_done_count", nd, 2);
        check("fault_pass_sticky", test_pass, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_axi_tester.md
Name: sram_axi_tester

Overview:
Self-checking external-SRAM memory tester for board bring-up.
- An internal pattern sequencer issues single-beat AXI-lite-style write and read transactions to an internal async-SRAM controller.
- The controller drives the SRAM pins.
- The tester writes a data pattern to every address, reads every address back, and compares.
- It reports a sticky pass flag and a per-pass done pulse, and loops forever.

Parameters:
ADDR_BITS, 10, SRAM address width; the test covers addresses 0..2^ADDR_BITS-1.
DATA_BITS, 8, SRAM data width.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high.
test_done  output  1  one-cycle pulse at the end of each full pass.
test_pass  output  1  high until the first read mismatch; sticky low until reset.
pattern_state  output  3  current pattern index (debug).
expected_data  output  DATA_BITS  expected value for the current address (debug).
read_data  output  DATA_BITS  last value read from SRAM (debug).
iter_addr  output  ADDR_BITS  current test address (debug).
sram_io_addr  output  ADDR_BITS  SRAM address pins.
sram_io_data  inout  DATA_BITS  SRAM data pins; driven only during writes, otherwise high-Z.
sram_io_we_n  output  1  write enable, active-low.
sram_io_oe_n  output  1  output enable, active-low.
sram_io_ce_n  output  1  chip enable, active-low.

Behaviour:
- Reset state:
  - test_pass=1, test_done=0, pattern_state=0, iter_addr=0, read_data=0.
  - we_n=1, oe_n=1, ce_n=1; data bus high-Z.
  - Sequencer in WRITE phase.
- Patterns, selected by pattern_state; expected_data is combinational from pattern_state and iter_addr:
  - 0: all zeros.
  - 1: all ones.
  - 2: 0101… alternating.
  - 3: 1010… alternating.
  - 4: iter_addr truncated/zero-extended to DATA_BITS.
  - 5: bitwise inverse of pattern 4.
  - Values 6 and 7 are unused.
- Sequencer FSM states: WRITE → WRITE_WAIT → (next addr) … → READ → READ_WAIT → CHECK → (next addr) … → next pattern.
  - WRITE phase: issue a write of expected_data at iter_addr and wait for the write response. If iter_addr is the last address, wrap iter_addr to 0 and enter the READ phase; otherwise increment iter_addr.
  - READ phase: issue a read at iter_addr and wait for rvalid. Latch rdata into read_data. In CHECK, if read_data != expected_data, clear test_pass (sticky). If iter_addr is the last address, wrap to 0; otherwise increment.
  - After READ of the last address: if pattern_state==5, pulse test_done for exactly one cycle, set pattern_state=0 and restart WRITE; otherwise increment pattern_state and restart WRITE.
- The tester never halts; it loops indefinitely.
- Internal AXI-lite link:
  - Channels: aw/w/b/ar/r with valid/ready.
  - A transfer occurs when valid&&ready on the same clk edge.
  - The master holds valid and payload stable until accepted.
  - Only one transaction is outstanding at a time.
  - bresp/rresp are always OKAY and ignored.
- SRAM controller write cycle, 3 clocks after aw and w are both accepted:
  - C1: addr and data driven, ce_n=0, we_n=1, oe_n=1.
  - C2: we_n=0.
  - C3: we_n=1, addr and data still held.
  - Then bvalid, and the bus is released.
- SRAM controller read cycle, after ar is accepted:
  - C1: addr, ce_n=0, oe_n=0, we_n=1.
  - C2: data still driven by SRAM; sample sram_io_data.
  - C3: rvalid with the sampled data; oe_n=1.
- Controller idle: ce_n=1, oe_n=1, we_n=1, data high-Z.
- Bus contention rules:
  - oe_n and we_n are never low simultaneously.
  - The tester never drives the data bus while oe_n=0.
- Reset mid-operation: all state is abandoned at once; pins return to idle on the next cycle and the pass restarts from pattern 0, address 0.
- Throughput budget: a full pass is ≤ 6 patterns × 2 × 2^ADDR_BITS × 6 cycles.
  - For ADDR_BITS=4 that is ≤ ~1200 cycles.
  - Two passes must complete well under 50000 cycles.
- All outputs are registered except expected_data.

Test Plan:
- ADDR_BITS=4, DATA_BITS=2 with a behavioural async SRAM (write on we_n low with ce_n low, read drives data when ce_n=0, oe_n=0, we_n=1). Reset for 2 cycles, then run → test_pass stays 1 every cycle after reset and test_done pulses twice within 50000 cycles.
- Same setup, measure the test_done interval → the cycles between two consecutive pulses are equal, and each pulse is exactly one cycle wide.
- Inject a stuck-at-0 fault on SRAM data bit 0 → test_pass falls to 0 during the pattern 1 (all ones) read of address 0, and stays 0 across later test_done pulses.
- Pin protocol checker running the whole time → never oe_n=0 && we_n=0; data is high-Z whenever oe_n=0; addr and data are stable across every we_n low pulse and one cycle after it.
- Assert reset mid-READ phase of pattern 3 → the next cycle shows idle pins, pattern_state=0, iter_addr=0, test_pass=1, and the full pass completes normally.
- Check the debug outputs during pattern 4 → expected_data equals iter_addr[1:0], and read_data matches it after each read.
